// File: rtl/alarm_ctrl.sv
// alarm_ctrl: button debounce, BCD counter strobes and SET/RUN/PAUSE/BEEP sequencing
// for the countdown alarm, including buzzer cadence.
module alarm_ctrl #(
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int BEEP_ON_MS      = 250,
    parameter int BEEP_OFF_MS     = 250,
    parameter int BEEP_TIMEOUT_S  = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       tick_s,
    input  logic       upbtn,
    input  logic       dnbtn,
    input  logic       startbtn,
    input  logic       cnt_zero,
    output logic       cnt_inc,
    output logic       cnt_dec,
    output logic [1:0] state,
    output logic       buzz
);
    localparam logic [1:0] SET = 2'b00, RUN = 2'b01, BEEP = 2'b10, PAUSE = 2'b11;
    localparam int DW   = $clog2(DEBOUNCE_MS + 1);
    localparam int RMAX = REPEAT_DELAY_MS > REPEAT_RATE_MS ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int BMAX = BEEP_ON_MS > BEEP_OFF_MS ? BEEP_ON_MS : BEEP_OFF_MS;
    localparam int BW   = $clog2(BMAX + 1);
    localparam int SW   = $clog2(BEEP_TIMEOUT_S + 1);
    localparam logic [RW-1:0] DLY_M1 = RW'(REPEAT_DELAY_MS - 1);
    localparam logic [RW-1:0] RATE_M1 = RW'(REPEAT_RATE_MS - 1);
    localparam logic [BW-1:0] ON_M1 = BW'(BEEP_ON_MS - 1);
    localparam logic [BW-1:0] OFF_M1 = BW'(BEEP_OFF_MS - 1);

    logic [2:0]    sync1, sync2, lvl, lvl_d, press;
    logic [DW-1:0] db_cnt [3];
    logic [RW-1:0] rpt;
    logic [BW-1:0] bms;
    logic [SW-1:0] sec;
    logic [1:0]    nstate;
    logic          rph, ph, ph_nxt, up_p, dn_p, st_p, one_held, rep_fire, timeout;
    logic          inc_n, dec_n, buzz_n;

    // bit 0 = up, bit 1 = dn, bit 2 = start; levels are active-low like the pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
            lvl   <= '1;
            lvl_d <= '1;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {startbtn, dnbtn, upbtn};
            sync2 <= sync1;
            lvl_d <= lvl;
            for (int i = 0; i < 3; i++)
                if (tick_ms) begin
                    if (sync2[i] == lvl[i]) db_cnt[i] <= '0;
                    else if (db_cnt[i] == DW'(DEBOUNCE_MS - 1)) begin
                        lvl[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else db_cnt[i] <= db_cnt[i] + 1'b1;
                end
        end
    end

    assign press    = lvl_d & ~lvl;
    assign up_p     = press[0];
    assign dn_p     = press[1];
    assign st_p     = press[2];
    assign one_held = lvl[0] ^ lvl[1];
    assign rep_fire = state == SET && one_held && tick_ms && !(up_p || dn_p) &&
                      rpt == (rph ? RATE_M1 : DLY_M1);
    assign ph_nxt   = (state == BEEP && tick_ms && bms == (ph ? OFF_M1 : ON_M1)) ? ~ph : ph;
    assign timeout  = state == BEEP && tick_s && sec == SW'(BEEP_TIMEOUT_S - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SET;
            cnt_inc <= 1'b0;
            cnt_dec <= 1'b0;
            buzz    <= 1'b0;
        end else begin
            state   <= nstate;
            cnt_inc <= inc_n & ~dec_n & ~cnt_inc;
            cnt_dec <= dec_n & ~inc_n & ~cnt_dec;
            buzz    <= buzz_n;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            SET:     nstate = (st_p && !cnt_zero) ? RUN : SET;
            RUN:     nstate = st_p ? PAUSE : cnt_zero ? BEEP : RUN;
            PAUSE:   nstate = st_p ? RUN : (up_p || dn_p) ? SET : PAUSE;
            default: nstate = (|press || timeout) ? SET : BEEP;
        endcase
    end

    // a press is only honoured while the opposite button is released
    always_comb begin
        inc_n  = state == SET && !st_p && lvl[1] && (up_p || (rep_fire && !lvl[0]));
        dec_n  = (state == SET && !st_p && lvl[0] && (dn_p || (rep_fire && !lvl[1]))) ||
                 (state == RUN && !st_p && !cnt_zero && tick_s);
        buzz_n = state == BEEP && nstate == BEEP && !ph_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt <= '0;
            rph <= 1'b0;
            bms <= '0;
            ph  <= 1'b0;
            sec <= '0;
        end else begin
            if (nstate != state || state != SET || !one_held || up_p || dn_p) begin
                rpt <= '0;
                rph <= 1'b0;
            end else if (rep_fire) begin
                rpt <= '0;
                rph <= 1'b1;
            end else if (tick_ms && rpt != RW'(RMAX)) rpt <= rpt + 1'b1;
            if (nstate != state || state != BEEP) begin
                bms <= '0;
                ph  <= 1'b0;
                sec <= '0;
            end else begin
                ph <= ph_nxt;
                if (tick_ms) bms <= (bms == (ph ? OFF_M1 : ON_M1)) ? '0 : bms + 1'b1;
                if (tick_s && sec != SW'(BEEP_TIMEOUT_S)) sec <= sec + 1'b1;
            end
        end
    end
endmodule

// File: doc/alarm_ctrl.md
# alarm_ctrl

Sequencing controller for the countdown alarm. Debounces the three active-low board buttons, generates increment/decrement strobes for the external three-digit BCD counter datapath, and steps through set/run/pause/beep modes. Drives the buzzer cadence. Sits between the board buttons, the ms/s tick divider and the BCD counter/7-segment scanner.

## Interface

Parameters:
- DEBOUNCE_MS, 20: consecutive identical tick_ms samples needed to change a debounced button level
- REPEAT_DELAY_MS, 500: ms from press event to first auto-repeat strobe
- REPEAT_RATE_MS, 100: ms between subsequent auto-repeat strobes
- BEEP_ON_MS, 250: buzz high phase length
- BEEP_OFF_MS, 250: buzz low phase length
- BEEP_TIMEOUT_S, 30: seconds in BEEP before automatic return to SET

Ports:
- clk  in  1  system clock, the only clock
- rst  in  1  asynchronous, active-low reset
- tick_ms  in  1  one-cycle strobe every 1 ms
- tick_s  in  1  one-cycle strobe every 1 s, coincident with a tick_ms
- upbtn  in  1  up button, active-low, asynchronous
- dnbtn  in  1  down button, active-low, asynchronous
- startbtn  in  1  start button, active-low, asynchronous
- cnt_zero  in  1  counter datapath reports 000
- cnt_inc  out  1  one-cycle increment strobe to counter
- cnt_dec  out  1  one-cycle decrement strobe to counter
- state  out  2  SET=00, RUN=01, BEEP=10, PAUSE=11
- buzz  out  1  buzzer drive, active-high

## Operation

- Each button passes through a 2-flop synchronizer, then a debouncer. The debouncer samples only on tick_ms. Its debounced level flips after DEBOUNCE_MS consecutive samples that differ from the current level; any matching sample clears the count. The reset level is released (1).
- A press event is a debounced 1→0 transition and is one cycle wide. A release produces no event.
- SET:
  - up press → cnt_inc; dn press → cnt_dec.
  - While exactly one of up/dn stays held, auto-repeat strobes occur REPEAT_DELAY_MS after the press, then every REPEAT_RATE_MS.
  - Both up and dn held: no strobes, and the repeat counter is held at 0.
  - start press with cnt_zero=0 → RUN. With cnt_zero=1, the state stays SET.
  - start press has priority over a same-cycle up/dn press; that up/dn press is dropped.
- RUN:
  - tick_s with cnt_zero=0 → cnt_dec.
  - cnt_zero=1 → BEEP, with no cnt_dec.
  - start press → PAUSE.
  - up/dn are ignored.
- PAUSE:
  - tick_s is ignored.
  - start press → RUN.
  - up or dn press → SET. The press that causes this transition generates no strobe.
- BEEP:
  - buzz runs BEEP_ON_MS high, then BEEP_OFF_MS low, repeating. Phase time is counted in tick_ms.
  - Any button press → SET with buzz=0.
  - After BEEP_TIMEOUT_S tick_s strobes counted in BEEP, the block returns to SET.
- cnt_inc and cnt_dec are never high in the same cycle, and each is never high for two consecutive cycles.
- All timers and counters are cleared on every state entry.

## Timing

- Reset (rst=0) takes effect immediately and asynchronously:
  - state=00, cnt_inc=0, cnt_dec=0, buzz=0.
  - Debounced levels are 1, and all counters are 0.
- Reset asserted mid-BEEP or mid-RUN drops buzz/strobes in the same instant. After release, operation restarts in SET.
- Press latency:
  - The debounced level updates at the edge that samples the DEBOUNCE_MS-th qualifying tick_ms.
  - The press event and any resulting strobe or state change register on the following edge, i.e. 1 cycle after the debounced level updates.
  - The 2-flop sync adds 2 cycles before the first qualifying sample.
- RUN cnt_dec is high exactly 1 cycle after the tick_s cycle.
- RUN→BEEP takes effect 1 cycle after cnt_zero is sampled high.
- Entry to RUN does not realign tick_s, so the first decrement may come after less than 1 s.
- buzz goes high 1 cycle after entering BEEP. Phase boundaries follow tick_ms with 1-cycle latency.
- If tick_s coincides with a start press in RUN, PAUSE wins and no cnt_dec is issued.
- If the timeout completes on the same edge as a button press in BEEP, the result is SET either way.
- Repeat timer arithmetic:
  - Counters saturate and never wrap.
  - Widths are $clog2 of (parameter+1).

## Test plan

1. Reset: drive rst=0 mid-BEEP with buzz=1 → buzz, cnt_inc, cnt_dec are 0 and state=00 before the next clk edge. After release, nothing happens for 10 ms idle.
2. Debounce, DEBOUNCE_MS=3:
   - upbtn low for 2 tick_ms then high → no cnt_inc.
   - upbtn low for 3 tick_ms → exactly one cnt_inc, 1 cycle after the debounced level changes.
3. Auto-repeat, DEBOUNCE_MS=3, REPEAT_DELAY_MS=10, REPEAT_RATE_MS=4: hold dnbtn 22 ms past the press event → 5 cnt_dec strobes, at press, +10, +14, +18, +22 ms. Holding up+dn together → 0 strobes.
4. Countdown, cnt_zero=0:
   - start press → state=01.
   - 3 tick_s → 3 cnt_dec strobes, each 1 cycle after tick_s.
   - Raise cnt_zero → state=10 one cycle later, and no further cnt_dec.
5. Beep cadence, BEEP_ON_MS=2, BEEP_OFF_MS=2, BEEP_TIMEOUT_S=3:
   - buzz sequence per tick_ms is 1,1,0,0,1.
   - startbtn press → state=00, buzz=0.
   - Separate run with no press → SET after the 3rd tick_s.
6. Guards:
   - In SET with cnt_zero=1, a start press leaves state=00.
   - In RUN, a start press gives state=11, and tick_s then produces no cnt_dec.
   - From PAUSE, an up press → state=00 with no cnt_inc.
